// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared types and constants for the multi-cycle control unit
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - datapath/memory control bundle between controller and datapath
interface multicycle_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctrl;
  logic        retire;
  logic        illegal;

  modport master (
    input  instr, mem_ready, zero,
    output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, retire, illegal
  );

  modport slave (
    output instr, mem_ready, zero,
    input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, retire, illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - ALU operation decode and legality for OP / OP-IMM
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter bit EXT_OPS = 1'b0
) (
  input  logic       funct7_5,
  input  logic [2:0] funct3,
  input  logic       is_imm,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    if (is_imm) begin
      // funct7 bits belong to the immediate for addi
      legal = EXT_OPS && (funct3 == 3'b000);
    end else begin
      case ({funct7_5, funct3})
        4'b0_000: begin alu_ctrl = ALU_ADD; legal = 1'b1;    end
        4'b1_000: begin alu_ctrl = ALU_SUB; legal = 1'b1;    end
        4'b0_111: begin alu_ctrl = ALU_AND; legal = 1'b1;    end
        4'b0_110: begin alu_ctrl = ALU_OR;  legal = 1'b1;    end
        4'b0_100: begin alu_ctrl = ALU_XOR; legal = EXT_OPS; end
        4'b0_010: begin alu_ctrl = ALU_SLT; legal = EXT_OPS; end
        default:  begin alu_ctrl = ALU_ADD; legal = 1'b0;    end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle instruction sequencer with mem_ready handshake
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  state_t     state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_imm;
  logic       ready;
  logic [2:0] dec_ctrl;
  logic       dec_legal;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign is_imm = (opcode == OPC_OP_IMM);
  assign ready  = MEM_WAIT ? bus.mem_ready : 1'b1;

  alu_decoder #(.EXT_OPS(EXT_OPS)) u_alu_decoder (
    .funct7_5 (bus.instr[30]),
    .funct3   (funct3),
    .is_imm   (is_imm),
    .alu_ctrl (dec_ctrl),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OPC_LOAD, OPC_STORE: state <= (funct3 == 3'b011) ? MEM_ADDR : TRAP;
            OPC_OP, OPC_OP_IMM:  state <= dec_legal ? EXEC : TRAP;
            OPC_BRANCH:          state <= (funct3 == 3'b000) ? BRANCH : TRAP;
            default:             state <= TRAP;
          endcase
        end
        MEM_ADDR: state <= (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
        MEM_RD:   if (ready) state <= MEM_WB;
        MEM_WR:   if (ready) state <= FETCH;
        EXEC:     state <= ALU_WB;
        MEM_WB, ALU_WB, BRANCH: state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  // Decoded from state so that reset silences every output in the same instant
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_ctrl   = 3'b000;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    if (!rst) begin
      bus.alu_ctrl = ALU_ADD;
      case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          bus.ir_write  = ready;
          bus.pc_write  = ready;
        end
        DECODE: begin
          bus.alu_src_a = SRC_A_OLD_PC;
          bus.alu_src_b = SRC_B_IMM;
        end
        MEM_ADDR: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_IMM;
        end
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.retire     = 1'b1;
        end
        MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          bus.retire    = ready;
        end
        EXEC: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = is_imm ? SRC_B_IMM : SRC_B_RS2;
          bus.alu_ctrl  = dec_ctrl;
        end
        ALU_WB: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = SRC_A_RS1;
          bus.alu_src_b = SRC_B_RS2;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = 1'b1;
          bus.pc_write  = bus.zero;
          bus.retire    = 1'b1;
        end
        TRAP:    bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multicycle_control_if i0 ();
  multicycle_control_if i1 ();

  multicycle_control #(.MEM_WAIT(1'b1), .EXT_OPS(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (i0.master)
  );
  multicycle_control #(.MEM_WAIT(1'b0), .EXT_OPS(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (i1.master)
  );

  function automatic logic [16:0] pk(input logic pcw, pcs, irw, iod, mr, mw, rw, m2r,
                                     input logic [1:0] a, b, input logic [2:0] alu,
                                     input logic ret, ill);
    return {pcw, pcs, irw, iod, mr, mw, rw, m2r, a, b, alu, ret, ill};
  endfunction

  function automatic logic [16:0] obs(input bit s);
    if (s)
      return {i1.pc_write, i1.pc_src, i1.ir_write, i1.i_or_d, i1.mem_read, i1.mem_write,
              i1.reg_write, i1.mem_to_reg, i1.alu_src_a, i1.alu_src_b, i1.alu_ctrl,
              i1.retire, i1.illegal};
    return {i0.pc_write, i0.pc_src, i0.ir_write, i0.i_or_d, i0.mem_read, i0.mem_write,
            i0.reg_write, i0.mem_to_reg, i0.alu_src_a, i0.alu_src_b, i0.alu_ctrl,
            i0.retire, i0.illegal};
  endfunction

  function automatic logic [3:0] st_of(input bit s);
    return s ? dut1.state : dut0.state;
  endfunction

  task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic set_instr(input bit s, input logic [31:0] v);
    if (s) i1.instr = v; else i0.instr = v;
  endtask

  // Called at posedge+1: drive ready/zero, sample mid-cycle, advance one clock
  task automatic cyc(input bit s, input logic r, input logic z, input state_t st,
                     input logic [16:0] e, input string tag);
    if (s) begin i1.mem_ready = r; i1.zero = z; end
    else   begin i0.mem_ready = r; i0.zero = z; end
    #2;
    chk({tag, "/state"}, 17'(st_of(s)), 17'(st));
    chk(tag, obs(s), e);
    @(posedge clk); #1;
  endtask

  logic [16:0] e_zero, e_f1, e_f0, e_dec, e_ex_add, e_ex_sub, e_ex_xor, e_ex_addi;
  logic [16:0] e_alu_wb, e_ma, e_mrd, e_mwb, e_wr0, e_wr1, e_br1, e_br0, e_trap;

  initial begin
    e_zero    = '0;
    e_f1      = pk(1,0,1,0,1,0,0,0, 2'b00, 2'b01, 3'b010, 0,0);
    e_f0      = pk(0,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b010, 0,0);
    e_dec     = pk(0,0,0,0,0,0,0,0, 2'b10, 2'b10, 3'b010, 0,0);
    e_ex_add  = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
    e_ex_sub  = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b110, 0,0);
    e_ex_xor  = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b011, 0,0);
    e_ex_addi = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b10, 3'b010, 0,0);
    e_alu_wb  = pk(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 1,0);
    e_ma      = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b10, 3'b010, 0,0);
    e_mrd     = pk(0,0,0,1,1,0,0,0, 2'b00, 2'b00, 3'b010, 0,0);
    e_mwb     = pk(0,0,0,0,0,0,1,1, 2'b00, 2'b00, 3'b010, 1,0);
    e_wr0     = pk(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b010, 0,0);
    e_wr1     = pk(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b010, 1,0);
    e_br1     = pk(1,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b110, 1,0);
    e_br0     = pk(0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b110, 1,0);
    e_trap    = pk(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0,1);

    i0.instr = 32'h0; i0.mem_ready = 1'b1; i0.zero = 1'b1;
    i1.instr = 32'h0; i1.mem_ready = 1'b1; i1.zero = 1'b1;

    // Reset with mem_ready high: Mealy terms must also be silenced
    @(negedge clk);
    chk("reset0", obs(0), e_zero);
    chk("reset1", obs(1), e_zero);
    chk("reset0/state", 17'(st_of(0)), 17'(FETCH));
    @(posedge clk); #1;
    rst = 1'b0;

    set_instr(0, 32'h003100b3);
    cyc(0, 1, 0, FETCH,  e_f1,     "add_fetch");
    cyc(0, 1, 0, DECODE, e_dec,    "add_decode");
    cyc(0, 1, 0, EXEC,   e_ex_add, "add_exec");
    cyc(0, 1, 0, ALU_WB, e_alu_wb, "add_wb");

    set_instr(0, 32'h02813083);
    cyc(0, 1, 0, FETCH,    e_f1,  "ld_fetch");
    cyc(0, 1, 0, DECODE,   e_dec, "ld_decode");
    cyc(0, 1, 0, MEM_ADDR, e_ma,  "ld_addr");
    cyc(0, 0, 0, MEM_RD,   e_mrd, "ld_rd_wait1");
    cyc(0, 0, 0, MEM_RD,   e_mrd, "ld_rd_wait2");
    cyc(0, 1, 0, MEM_RD,   e_mrd, "ld_rd_done");
    cyc(0, 1, 0, MEM_WB,   e_mwb, "ld_wb");

    set_instr(0, 32'h02113423);
    cyc(0, 1, 0, FETCH,    e_f1,  "sd_fetch");
    cyc(0, 1, 0, DECODE,   e_dec, "sd_decode");
    cyc(0, 1, 0, MEM_ADDR, e_ma,  "sd_addr");
    cyc(0, 0, 0, MEM_WR,   e_wr0, "sd_wr_wait");
    cyc(0, 1, 0, MEM_WR,   e_wr1, "sd_wr_done");

    set_instr(0, 32'h02208463);
    cyc(0, 1, 1, FETCH,  e_f1,  "beq1_fetch");
    cyc(0, 1, 1, DECODE, e_dec, "beq1_decode");
    cyc(0, 1, 1, BRANCH, e_br1, "beq_taken");
    cyc(0, 1, 0, FETCH,  e_f1,  "beq0_fetch");
    cyc(0, 1, 0, DECODE, e_dec, "beq0_decode");
    cyc(0, 1, 0, BRANCH, e_br0, "beq_not_taken");

    set_instr(0, 32'h403100b3);
    cyc(0, 1, 0, FETCH,  e_f1,     "sub_fetch");
    cyc(0, 1, 0, DECODE, e_dec,    "sub_decode");
    cyc(0, 1, 0, EXEC,   e_ex_sub, "sub_exec");
    cyc(0, 1, 0, ALU_WB, e_alu_wb, "sub_wb");

    set_instr(0, 32'h003140b3);
    cyc(0, 1, 0, FETCH,  e_f1,   "xor_noext_fetch");
    cyc(0, 1, 0, DECODE, e_dec,  "xor_noext_decode");
    cyc(0, 1, 0, TRAP,   e_trap, "xor_trap");
    cyc(0, 0, 1, TRAP,   e_trap, "xor_trap_sticky");

    // Reset clears the trap
    rst = 1'b1;
    #2;
    chk("trap_rst", obs(0), e_zero);
    chk("trap_rst/state", 17'(st_of(0)), 17'(FETCH));
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a fetch wait
    cyc(0, 0, 0, FETCH, e_f0, "fetch_wait1");
    i0.mem_ready = 1'b0;
    #2;
    chk("fetch_wait2", obs(0), e_f0);
    rst = 1'b1;
    #1;
    chk("rst_mid_fetch", obs(0), e_zero);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("post_rst_fetch", obs(0), e_f0);
    @(posedge clk); #1;

    // Extended ops, memory wait ignored
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_instr(1, 32'h003140b3);
    cyc(1, 0, 0, FETCH,  e_f1,     "xor_ext_fetch_noready");
    cyc(1, 0, 0, DECODE, e_dec,    "xor_ext_decode");
    cyc(1, 0, 0, EXEC,   e_ex_xor, "xor_ext_exec");
    cyc(1, 0, 0, ALU_WB, e_alu_wb, "xor_ext_wb");
    set_instr(1, 32'h00a10093);
    cyc(1, 0, 0, FETCH,  e_f1,      "addi_fetch");
    cyc(1, 0, 0, DECODE, e_dec,     "addi_decode");
    cyc(1, 0, 0, EXEC,   e_ex_addi, "addi_exec");
    cyc(1, 0, 0, ALU_WB, e_alu_wb,  "addi_wb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
